// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/ROM fetch front end with branch LUT and req->run->done control; define FETCH_REL_BRANCH_EN for PC-relative LUT targets.
module fetch_sequencer #(
  parameter int D        = 8,
  parameter int IW       = 9,
  parameter int END_ADDR = 128,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          branch_en,
  input  logic [2:0]    branch_sel,
  input  logic          lut_we,
  input  logic [2:0]    lut_addr,
  input  logic [D-1:0]  lut_data,
  output logic [D-1:0]  imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic [D-1:0]  prog_ctr,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [D-1:0]  prog_ctr_q, prog_ctr_d, target, next_pc;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [D-1:0]  lut_q [8];
  logic [D-1:0]  lut_d [8];
  always_comb begin
`ifdef FETCH_REL_BRANCH_EN
    target = prog_ctr_q + lut_q[branch_sel];
`else
    target = lut_q[branch_sel];
`endif
    next_pc = branch_en ? target : prog_ctr_q + 1'b1;
    lut_d = lut_q;
    if (lut_we) lut_d[lut_addr] = lut_data;
    state_d = state_q;
    prog_ctr_d = prog_ctr_q;
    cycle_cnt_d = cycle_cnt_q;
    if (state_q == RUN) begin
      prog_ctr_d = next_pc;
      cycle_cnt_d = cycle_cnt_q + CW'(~&cycle_cnt_q);
      state_d = (next_pc == D'(END_ADDR)) ? DONE : RUN;
    end else if (req) begin
      state_d = RUN;
      prog_ctr_d = '0;
      cycle_cnt_d = '0;
    end
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prog_ctr_q <= '0;
      cycle_cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      lut_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      prog_ctr_q <= prog_ctr_d;
      cycle_cnt_q <= cycle_cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      lut_q <= lut_d;
    end
  end
  assign imem_addr = prog_ctr_q;
  assign prog_ctr = prog_ctr_q;
  assign cycle_cnt = cycle_cnt_q;
  assign busy = busy_q;
  assign done = done_q;
  assign instr_valid = state_q == RUN;
  assign instr = (state_q == RUN) ? imem_data : '0;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random and directed stimulus checked each cycle against a behavioural model.
module tb_fetch_sequencer;
`ifdef FETCH_REL_BRANCH_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, req = 1'b0, branch_en = 1'b0, lut_we = 1'b0;
  logic [2:0] branch_sel = '0, lut_addr = '0;
  logic [7:0] lut_data = '0, imem_addr, prog_ctr;
  logic [8:0] imem_data, instr;
  logic instr_valid, busy, done;
  logic [15:0] cycle_cnt;
  logic [8:0] rom [256];
  int vec = 0, err = 0, n;
  bit m_live = 1'b0;
  int m_state = 0;
  logic [7:0] m_pc = '0, m_tgt, m_nxt;
  logic [7:0] m_lut [8];
  int m_cnt = 0;
  fetch_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .branch_en(branch_en), .branch_sel(branch_sel),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid), .prog_ctr(prog_ctr),
    .busy(busy), .done(done), .cycle_cnt(cycle_cnt)
  );
  always #5 clk = ~clk;
  assign imem_data = rom[imem_addr];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model state: 0 idle, 1 running, 2 finished.
  always @(posedge clk) begin
    if (reset) begin
      m_state = 0; m_pc = '0; m_cnt = 0; m_live = 1'b1;
      for (int i = 0; i < 8; i++) m_lut[i] = '0;
    end else begin
      m_tgt = REL ? m_pc + m_lut[branch_sel] : m_lut[branch_sel];
      if (m_state == 1) begin
        m_nxt = branch_en ? m_tgt : m_pc + 8'd1;
        m_pc = m_nxt;
        m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
        if (m_nxt == 8'd128) m_state = 2;
      end else if (req) begin
        m_state = 1; m_pc = '0; m_cnt = 0;
      end
      if (lut_we) m_lut[lut_addr] = lut_data;
    end
  end
  always @(negedge clk) if (m_live) begin
    check("imem_addr", imem_addr, m_pc);
    check("prog_ctr", prog_ctr, m_pc);
    check("instr_valid", instr_valid, m_state == 1);
    check("instr", instr, (m_state == 1) ? rom[m_pc] : 9'd0);
    check("busy", busy, m_state == 1);
    check("done", done, m_state == 2);
    check("cycle_cnt", cycle_cnt, m_cnt);
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic pulse_req();
    req = 1'b1; tick(); req = 1'b0;
  endtask
  task automatic lut_wr(input logic [2:0] a, input logic [7:0] d);
    lut_we = 1'b1; lut_addr = a; lut_data = d; tick(); lut_we = 1'b0;
  endtask
  task automatic run_to(input logic [7:0] pc);
    for (int i = 0; i < 300 && prog_ctr != pc; i++) tick();
    check("run_to", prog_ctr, pc);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 300 && !done; i++) tick();
    check("wait_done", done, 1);
  endtask
  task automatic branch(input logic [2:0] s);
    branch_en = 1'b1; branch_sel = s; tick(); branch_en = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'($urandom);
    tick(); tick(); reset = 1'b0;
    check("rst_pc", prog_ctr, 0); check("rst_busy", busy, 0); check("rst_done", done, 0);
    check("rst_cnt", cycle_cnt, 0); check("rst_valid", instr_valid, 0); check("rst_instr", instr, 0);
    pulse_req();
    check("first_pc", prog_ctr, 0); check("first_valid", instr_valid, 1);
    n = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (instr_valid) n++;
      tick();
    end
    check("valid_count", n, 128); check("end_pc", prog_ctr, 128); check("end_cnt", cycle_cnt, 128);
    check("end_done", done, 1); check("end_busy", busy, 0);
    tick();
    check("frozen_pc", prog_ctr, 128); check("frozen_cnt", cycle_cnt, 128);
`ifdef FETCH_REL_BRANCH_EN
    lut_wr(3'd1, 8'hFC); lut_wr(3'd5, 8'd237);
    pulse_req(); run_to(8'd20);
    branch(3'd1);
    check("rel_back", prog_ctr, 16);
    lut_we = 1'b1; lut_addr = 3'd1; lut_data = 8'd5;
    branch(3'd5); lut_we = 1'b0;
    check("rel_fwd", prog_ctr, 253);
    branch(3'd1);
    check("rel_wrap", prog_ctr, 2);
    wait_done();
`else
    lut_wr(3'd3, 8'd40);
    pulse_req(); run_to(8'd10);
    n = cycle_cnt;
    branch(3'd3);
    check("abs_br", prog_ctr, 40); check("abs_cnt", cycle_cnt, n + 1);
    lut_we = 1'b1; lut_addr = 3'd4; lut_data = 8'd128; tick(); lut_we = 1'b0;
    check("abs_next", prog_ctr, 41);
    branch(3'd4);
    check("br_end_done", done, 1); check("br_end_pc", prog_ctr, 128);
`endif
    lut_wr(3'd2, 8'd5);
    pulse_req();
    check("restart_pc", prog_ctr, 0); check("restart_done", done, 0);
    check("restart_busy", busy, 1); check("restart_cnt", cycle_cnt, 0);
    run_to(8'd3);
    lut_we = 1'b1; lut_addr = 3'd2; lut_data = 8'd77;
    branch(3'd2); lut_we = 1'b0;
    check("collide_old", prog_ctr, REL ? 8 : 5);
    branch(3'd2);
    check("collide_new", prog_ctr, REL ? 85 : 77);
    wait_done();
    pulse_req(); run_to(8'd20);
    pulse_req();
    check("ignore_req_pc", prog_ctr, 21); check("ignore_req_busy", busy, 1);
    run_to(8'd50);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_pc", prog_ctr, 0); check("midrst_busy", busy, 0); check("midrst_done", done, 0);
    check("midrst_cnt", cycle_cnt, 0); check("midrst_valid", instr_valid, 0);
    pulse_req(); run_to(8'd5);
    branch(3'd3);
    check("lut_cleared", prog_ctr, REL ? 5 : 0);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 299) == 0;
      req = $urandom_range(0, 19) == 0;
      branch_en = $urandom_range(0, 7) == 0;
      branch_sel = 3'($urandom);
      lut_we = $urandom_range(0, 3) == 0;
      lut_addr = 3'($urandom);
      lut_data = ($urandom_range(0, 3) == 0) ? 8'd128 : 8'($urandom);
      tick();
    end
    reset = 1'b0; req = 1'b0; branch_en = 1'b0; lut_we = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch front end and run controller for the 9-bit-instruction single-cycle core.
- Holds the program counter and drives the instruction ROM address.
- Presents the fetched machine code to the decode/execute datapath.
- Owns the 8-entry branch-target lookup table, the req→run→done handshake, and a run-cycle counter.

Parameters:
- D, 8, program counter / ROM address width.
- IW, 9, instruction width.
- END_ADDR, 128, PC value that terminates the program. Must be < 2^D.
- CW, 16, cycle counter width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- req  input  1  start request; sampled each cycle
- branch_en  input  1  from decode: take the branch this cycle
- branch_sel  input  3  LUT index for the branch target
- lut_we  input  1  LUT write enable
- lut_addr  input  3  LUT write index
- lut_data  input  D  LUT write data
- imem_addr  output  D  ROM address; equals prog_ctr
- imem_data  input  IW  ROM read data; combinational, same cycle
- instr  output  IW  machine code to decode
- instr_valid  output  1  instr is executable this cycle
- prog_ctr  output  D  current PC
- busy  output  1  program running
- done  output  1  program finished; held
- cycle_cnt  output  CW  cycles spent in RUN

Behaviour:
- Clock and reset: single clock, rising edge. reset is synchronous, active-high and overrides everything.
- Reset values:
  - state=IDLE, prog_ctr=0, busy=0, done=0, cycle_cnt=0.
  - All 8 LUT entries = 0.
  - instr_valid=0, instr=0.
- States: IDLE, RUN, DONE. All outputs are registered except instr and instr_valid.
- imem_addr = prog_ctr at all times.
- instr = imem_data when state==RUN, else 0. instr_valid = (state==RUN).
- busy = (state==RUN). done = (state==DONE).
- IDLE:
  - req=1 → RUN next cycle, prog_ctr<=0, cycle_cnt<=0.
  - branch_en is ignored.
- RUN:
  - Each cycle, next_pc = branch_en ? target : prog_ctr+1, with target = lut[branch_sel]. Arithmetic is modulo 2^D, so 2^D−1 wraps to 0.
  - prog_ctr<=next_pc. cycle_cnt<=cycle_cnt+1, saturating at 2^CW−1.
  - If next_pc==END_ADDR → DONE. This applies whether END_ADDR is reached by increment or by branch.
  - The instruction at END_ADDR is never marked valid.
  - req is ignored while in RUN.
- DONE:
  - prog_ctr, cycle_cnt and done are frozen.
  - req=1 → RUN, prog_ctr<=0, cycle_cnt<=0, done clears on the same edge.
- Latency:
  - The first instruction (address 0) is valid on the cycle after req is sampled.
  - done asserts the cycle after the final valid instruction.
- LUT write:
  - lut_we=1 writes lut[lut_addr]<=lut_data on the clock edge. Allowed in any state.
  - A same-cycle branch read of the entry being written uses the OLD value; the new value is visible the following cycle.
- Reset mid-RUN: next cycle is IDLE with all reset values; any in-flight branch is discarded; the LUT is cleared.
- branch_sel is don't-care when branch_en=0.

Optional Feature:
- Macro FETCH_REL_BRANCH_EN.
- Defined: the LUT entry is a two's-complement D-bit offset, and target = prog_ctr + lut[branch_sel] (mod 2^D). The END_ADDR check applies to the resulting target.
- Undefined: target = lut[branch_sel] as an absolute address. This is the default build.

Test Plan:
- Straight-line run: after reset, pulse req at cycle 0 → instr_valid from cycle 1, prog_ctr 0..127 consecutive, done=1 and busy=0 once next_pc=128, cycle_cnt=128, prog_ctr frozen at 128.
- Absolute branch: lut[3]=8'd40. At prog_ctr=10, branch_en=1, branch_sel=3 → next prog_ctr=40, then 41. cycle_cnt continues incrementing. Branch to lut entry 128 → done next cycle.
- LUT write/read collision: lut[2]=5. In one cycle, write lut[2]=77 and branch with sel=2 → PC=5. A later branch with sel=2 → 77.
- Restart and ignore: req during RUN at PC=20 → no change. req in DONE → PC=0, done=0, busy=1, cycle_cnt=0 next cycle.
- Reset mid-run: reset at PC=50 → next cycle state IDLE, PC=0, done=0, busy=0, cycle_cnt=0, instr_valid=0, lut[3] reads back 0 (checked by a branch after restart going to 0).
- FETCH_REL_BRANCH_EN build: lut[1]=8'hFC (−4). Branch at PC=20 → 16. lut[1]=8'h05 at PC=253 → PC=2 (wrap).
